// File: rtl/issueque_int_if.sv
// Issue-queue port bundle: dispatch, CDB snoop, issue bundle and occupancy status.
// The queue side uses the slave modport; whoever drives dispatch/CDB uses master.
interface issueque_int_if #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              dispatch_en;
  logic [OP_W-1:0]   dispatch_opcode;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic              dispatch_rsvalid;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_stall;
  logic              issueque_full;
  logic              issueque_dispatch_ok;
  logic [CNT_W-1:0]  issueque_count;
  logic              issueint_ready;
  logic [OP_W-1:0]   issueint_opcode;
  logic [DATA_W-1:0] issueint_rsdata;
  logic [DATA_W-1:0] issueint_rtdata;
  logic [TAG_W-1:0]  issueint_rdtag;

  modport slave (
    input  flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
           dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
           dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issue_stall,
    output issueque_full, issueque_dispatch_ok, issueque_count, issueint_ready,
           issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag
  );

  modport master (
    output flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
           dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
           dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issue_stall,
    input  issueque_full, issueque_dispatch_ok, issueque_count, issueint_ready,
           issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag
  );
endinterface

// File: rtl/issueque_int.sv
// Integer issue queue: collapsing reservation station, CDB wakeup, oldest-ready issue.
// Optional ISSUEQUE_INT_CDB_BYPASS_EN: capture a same-cycle CDB broadcast at dispatch.
module issueque_int #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic          clk,
  input  logic          reset,
  issueque_int_if.slave iq
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] rsdata;
    logic              rsvalid;
    logic [TAG_W-1:0]  rstag;
    logic [DATA_W-1:0] rtdata;
    logic              rtvalid;
    logic [TAG_W-1:0]  rttag;
    logic [TAG_W-1:0]  rdtag;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            new_ent;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  count_after;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              full;
  logic              dispatch_ok;
  logic              do_dispatch;
  logic              do_issue;
  logic              ready_q;
  logic [OP_W-1:0]   opcode_q;
  logic [DATA_W-1:0] rsdata_q;
  logic [DATA_W-1:0] rtdata_q;
  logic [TAG_W-1:0]  rdtag_q;

  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
    entry_t r;
    r = e;
    if (cv && !r.rsvalid && (r.rstag == ct)) begin
      r.rsvalid = 1'b1;
      r.rsdata  = cd;
    end
    if (cv && !r.rtvalid && (r.rttag == ct)) begin
      r.rtvalid = 1'b1;
      r.rtdata  = cd;
    end
    return r;
  endfunction

  assign full = (count_q == CNT_W'(DEPTH));
`ifdef ISSUEQUE_INT_CDB_BYPASS_EN
  assign dispatch_ok = !full;
`else
  assign dispatch_ok = !full && !iq.cdb_valid;
`endif
  assign do_dispatch = iq.dispatch_en && dispatch_ok;
  assign do_issue    = sel_found && !iq.issue_stall;

  // Selection looks only at registered state, so a wakeup this edge issues next cycle at the earliest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((i < int'(count_q)) && ent_q[i].rsvalid && ent_q[i].rtvalid) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.opcode  = iq.dispatch_opcode;
    new_ent.rsdata  = iq.dispatch_rsdata;
    new_ent.rsvalid = iq.dispatch_rsvalid;
    new_ent.rstag   = iq.dispatch_rstag;
    new_ent.rtdata  = iq.dispatch_rtdata;
    new_ent.rtvalid = iq.dispatch_rtvalid;
    new_ent.rttag   = iq.dispatch_rttag;
    new_ent.rdtag   = iq.dispatch_rdtag;
`ifdef ISSUEQUE_INT_CDB_BYPASS_EN
    new_ent = wake(new_ent, iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
`endif
  end

  // Collapse above the issued slot, apply wakeup, then append the dispatched op at the new tail.
  always_comb begin
    count_after = count_q - CNT_W'(do_issue);
    for (int j = 0; j < DEPTH; j++) begin
      ent_d[j] = '0;
      if (do_issue && (j >= int'(sel_idx))) begin
        if (j < DEPTH - 1) begin
          ent_d[j] = wake(ent_q[(j + 1) % DEPTH], iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
        end
      end else begin
        ent_d[j] = wake(ent_q[j], iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
      end
      if (do_dispatch && (j == int'(count_after))) begin
        ent_d[j] = new_ent;
      end
    end
    if (iq.flush) begin
      count_d = '0;
    end else begin
      count_d = count_after + CNT_W'(do_dispatch);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      ready_q  <= 1'b0;
      opcode_q <= '0;
      rsdata_q <= '0;
      rtdata_q <= '0;
      rdtag_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      if (iq.flush) begin
        ready_q <= 1'b0;
      end else if (!iq.issue_stall) begin
        ready_q <= sel_found;
        if (sel_found) begin
          opcode_q <= ent_q[sel_idx].opcode;
          rsdata_q <= ent_q[sel_idx].rsdata;
          rtdata_q <= ent_q[sel_idx].rtdata;
          rdtag_q  <= ent_q[sel_idx].rdtag;
        end
      end
    end
  end

  assign iq.issueque_full        = full;
  assign iq.issueque_dispatch_ok = dispatch_ok;
  assign iq.issueque_count       = count_q;
  assign iq.issueint_ready       = ready_q;
  assign iq.issueint_opcode      = opcode_q;
  assign iq.issueint_rsdata      = rsdata_q;
  assign iq.issueint_rtdata      = rtdata_q;
  assign iq.issueint_rdtag       = rdtag_q;
endmodule

// File: tb/tb_issueque_int.sv
// Directed bench for issueque_int: per-cycle vector table plus hand-written reset,
// double-wakeup and latency sequences.
module tb_issueque_int;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  issueque_int_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  issueque_int #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .iq    (bus)
  );

  typedef struct {
    logic              en;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] rs;
    logic              rsv;
    logic [TAG_W-1:0]  rstag;
    logic [DATA_W-1:0] rt;
    logic              rtv;
    logic [TAG_W-1:0]  rttag;
    logic [TAG_W-1:0]  rd;
    logic              cv;
    logic [TAG_W-1:0]  ctag;
    logic [DATA_W-1:0] cdata;
    logic              stall;
    logic              flush;
    logic              e_ok;
    logic              e_ready;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_rs;
    logic [DATA_W-1:0] e_rt;
    logic [TAG_W-1:0]  e_rd;
    logic [2:0]        e_count;
    logic              e_full;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   assertCount = 0;
  int   failCount   = 0;

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearCur();
    cur = '{default: '0};
  endtask

  task automatic setDisp(input int op, input int rs, input int rsv, input int rstag,
                         input int rt, input int rtv, input int rttag, input int rd);
    cur.en    = 1'b1;
    cur.op    = OP_W'(op);
    cur.rs    = DATA_W'(rs);
    cur.rsv   = rsv[0];
    cur.rstag = TAG_W'(rstag);
    cur.rt    = DATA_W'(rt);
    cur.rtv   = rtv[0];
    cur.rttag = TAG_W'(rttag);
    cur.rd    = TAG_W'(rd);
  endtask

  task automatic setCdb(input int tag, input int data);
    cur.cv    = 1'b1;
    cur.ctag  = TAG_W'(tag);
    cur.cdata = DATA_W'(data);
  endtask

  task automatic push(input int ok, input int ready, input int op, input int rs,
                      input int rt, input int rd, input int cnt, input int full);
    cur.e_ok    = ok[0];
    cur.e_ready = ready[0];
    cur.e_op    = OP_W'(op);
    cur.e_rs    = DATA_W'(rs);
    cur.e_rt    = DATA_W'(rt);
    cur.e_rd    = TAG_W'(rd);
    cur.e_count = 3'(cnt);
    cur.e_full  = full[0];
    vecs.push_back(cur);
    clearCur();
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.dispatch_en      = v.en;
    bus.dispatch_opcode  = v.op;
    bus.dispatch_rsdata  = v.rs;
    bus.dispatch_rsvalid = v.rsv;
    bus.dispatch_rstag   = v.rstag;
    bus.dispatch_rtdata  = v.rt;
    bus.dispatch_rtvalid = v.rtv;
    bus.dispatch_rttag   = v.rttag;
    bus.dispatch_rdtag   = v.rd;
    bus.cdb_valid        = v.cv;
    bus.cdb_tag          = v.ctag;
    bus.cdb_data         = v.cdata;
    bus.issue_stall      = v.stall;
    bus.flush            = v.flush;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, ".ready"}, 32'(bus.issueint_ready),  32'(v.e_ready));
    checkVal({tag, ".op"},    32'(bus.issueint_opcode), 32'(v.e_op));
    checkVal({tag, ".rs"},    bus.issueint_rsdata,      v.e_rs);
    checkVal({tag, ".rt"},    bus.issueint_rtdata,      v.e_rt);
    checkVal({tag, ".rd"},    32'(bus.issueint_rdtag),  32'(v.e_rd));
    checkVal({tag, ".count"}, 32'(bus.issueque_count),  32'(v.e_count));
    checkVal({tag, ".full"},  32'(bus.issueque_full),   32'(v.e_full));
  endtask

  // Bound on the whole run in case the DUT or a sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bypassOk;
    int cycles;
`ifdef ISSUEQUE_INT_CDB_BYPASS_EN
    bypassOk = 1;
`else
    bypassOk = 0;
`endif
    clearCur();
    applyStimulus(cur);
    reset = 1'b1;
    #2;
    push(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(vecs[0], "reset");
    vecs.delete();
    @(negedge clk);
    reset = 1'b0;

    // ADD ready at dispatch issues one edge later.
    setDisp(0, 5, 1, 0, 7, 1, 0, 3);             push(1, 0, 0, 0, 0, 0, 1, 0);
                                                 push(1, 1, 0, 5, 7, 3, 0, 0);
                                                 push(1, 0, 0, 5, 7, 3, 0, 0);
    // SUB waits on rs tag 0x0A.
    setDisp(1, 0, 0, 'h0A, 1, 1, 0, 4);          push(1, 0, 0, 5, 7, 3, 1, 0);
                                                 push(1, 0, 0, 5, 7, 3, 1, 0);
                                                 push(1, 0, 0, 5, 7, 3, 1, 0);
    setCdb('h0A, 'h20);                          push(bypassOk, 0, 0, 5, 7, 3, 1, 0);
                                                 push(1, 1, 1, 'h20, 1, 4, 0, 0);
                                                 push(1, 0, 1, 'h20, 1, 4, 0, 0);
    // Younger ready B overtakes older waiting A.
    setDisp(2, 'h10, 1, 0, 0, 0, 5, 6);          push(1, 0, 1, 'h20, 1, 4, 1, 0);
    setDisp(3, 'h30, 1, 0, 'h31, 1, 0, 7);       push(1, 0, 1, 'h20, 1, 4, 2, 0);
                                                 push(1, 1, 3, 'h30, 'h31, 7, 1, 0);
    setCdb(5, 'h55);                             push(bypassOk, 0, 3, 'h30, 'h31, 7, 1, 0);
                                                 push(1, 1, 2, 'h10, 'h55, 6, 0, 0);
                                                 push(1, 0, 2, 'h10, 'h55, 6, 0, 0);
    // Fill with waiting ops, drop a fifth, flush (dispatch and wakeup discarded).
    for (int i = 0; i < 4; i++) begin
      setDisp(i, 0, 0, 'h20 + i, 1, 1, 0, 'h20 + i);
      push(1, 0, 2, 'h10, 'h55, 6, i + 1, (i == 3) ? 1 : 0);
    end
    setDisp(9, 1, 1, 0, 1, 1, 0, 1);             push(0, 0, 2, 'h10, 'h55, 6, 4, 1);
    setDisp(9, 1, 1, 0, 1, 1, 0, 1); setCdb('h20, 1); cur.flush = 1'b1;
                                                 push(0, 0, 2, 'h10, 'h55, 6, 0, 0);
                                                 push(1, 0, 2, 'h10, 'h55, 6, 0, 0);
    // Stall with two ready entries, then release.
    setDisp(4, 1, 1, 0, 2, 1, 0, 8); cur.stall = 1'b1;  push(1, 0, 2, 'h10, 'h55, 6, 1, 0);
    setDisp(5, 3, 1, 0, 4, 1, 0, 9); cur.stall = 1'b1;  push(1, 0, 2, 'h10, 'h55, 6, 2, 0);
    for (int i = 0; i < 3; i++) begin
      cur.stall = 1'b1;                          push(1, 0, 2, 'h10, 'h55, 6, 2, 0);
    end
                                                 push(1, 1, 4, 1, 2, 8, 1, 0);
                                                 push(1, 1, 5, 3, 4, 9, 0, 0);
                                                 push(1, 0, 5, 3, 4, 9, 0, 0);
    // Issue plus dispatch in one edge, then stall holds a live bundle.
    setDisp(6, 'hA, 1, 0, 'hB, 1, 0, 10);        push(1, 0, 5, 3, 4, 9, 1, 0);
    setDisp(7, 'hC, 1, 0, 'hD, 1, 0, 11);        push(1, 1, 6, 'hA, 'hB, 10, 1, 0);
    cur.stall = 1'b1;                            push(1, 1, 6, 'hA, 'hB, 10, 1, 0);
    cur.stall = 1'b1;                            push(1, 1, 6, 'hA, 'hB, 10, 1, 0);
                                                 push(1, 1, 7, 'hC, 'hD, 11, 0, 0);
                                                 push(1, 0, 7, 'hC, 'hD, 11, 0, 0);
    // Full + issue: no dispatch into the slot freed that edge; flush beats issue.
    for (int i = 0; i < 4; i++) begin
      setDisp(8 + i, i, 1, 0, 16 + i, 1, 0, 12 + i); cur.stall = 1'b1;
      push(1, 0, 7, 'hC, 'hD, 11, i + 1, (i == 3) ? 1 : 0);
    end
    setDisp(15, 1, 1, 0, 1, 1, 0, 1);            push(0, 1, 8, 0, 16, 12, 3, 0);
    cur.flush = 1'b1;                            push(1, 0, 8, 0, 16, 12, 0, 0);
    // Dispatch during a broadcast of the operand's own tag.
    setDisp(12, 0, 0, 'h11, 2, 1, 0, 13); setCdb('h11, 9);
`ifdef ISSUEQUE_INT_CDB_BYPASS_EN
                                                 push(1, 0, 8, 0, 16, 12, 1, 0);
                                                 push(1, 1, 12, 9, 2, 13, 0, 0);
`else
                                                 push(0, 0, 8, 0, 16, 12, 0, 0);
                                                 push(1, 0, 8, 0, 16, 12, 0, 0);
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      #1;
      checkVal($sformatf("v%0d.dispatch_ok", k), 32'(bus.issueque_dispatch_ok), 32'(vecs[k].e_ok));
      @(posedge clk);
      #1;
      checkOutput(vecs[k], $sformatf("v%0d", k));
    end

    // Reset mid-queue clears everything without a clock edge.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clearCur(); setDisp(1, 0, 0, 'h30 + i, 1, 1, 0, 1);
      applyStimulus(cur);
      @(posedge clk);
      #1;
    end
    checkVal("midq.count", 32'(bus.issueque_count), 32'd2);
    @(negedge clk);
    clearCur(); applyStimulus(cur);
    #2;
    reset = 1'b1;
    #1;
    push(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(vecs[vecs.size() - 1], "async_reset");
    @(negedge clk);
    reset = 1'b0;

    // One broadcast wakes rs and rt together; no issue in the waking cycle.
    @(negedge clk);
    clearCur(); setDisp(9, 0, 0, 7, 0, 0, 7, 20); applyStimulus(cur);
    @(posedge clk); #1;
    @(negedge clk);
    clearCur(); setCdb(7, 'h77); applyStimulus(cur);
    @(posedge clk); #1;
    checkVal("wake.no_same_cycle_issue", 32'(bus.issueint_ready), 32'd0);
    @(negedge clk);
    clearCur(); applyStimulus(cur);
    @(posedge clk); #1;
    checkVal("wake.ready", 32'(bus.issueint_ready), 32'd1);
    checkVal("wake.rs", bus.issueint_rsdata, 32'h77);
    checkVal("wake.rt", bus.issueint_rtdata, 32'h77);
    checkVal("wake.rd", 32'(bus.issueint_rdtag), 32'd20);

    // Ready-at-dispatch latency, bounded wait.
    @(negedge clk);
    clearCur(); setDisp(10, 'h1234, 1, 0, 'h5678, 1, 0, 21); applyStimulus(cur);
    @(posedge clk); #1;
    @(negedge clk);
    clearCur(); applyStimulus(cur);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!bus.issueint_ready && cycles < 4);
    checkVal("latency.cycles", 32'(cycles), 32'd1);
    checkVal("latency.rs", bus.issueint_rsdata, 32'h1234);
    checkVal("latency.op", 32'(bus.issueint_opcode), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
